// File: rtl/tile_reveal.sv
// tile_reveal: per-tile board state, neighbour mine counting on reveal, flag/reveal counters and win/lose status
module tile_reveal #(
  parameter int MAX_DIM = 16,
  parameter int IDX_W   = 5,
  parameter int CNT_W   = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             new_game,
  input  logic [IDX_W-1:0] dim,
  input  logic [5:0]       mines,
  input  logic             click_valid,
  input  logic             explode,
  input  logic             flag_valid,
  input  logic [IDX_W-1:0] tile_x,
  input  logic [IDX_W-1:0] tile_y,
  output logic [IDX_W-1:0] mine_rd_x,
  output logic [IDX_W-1:0] mine_rd_y,
  input  logic             mine_rd_bit,
  input  logic [IDX_W-1:0] draw_x,
  input  logic [IDX_W-1:0] draw_y,
  output logic [3:0]       draw_state,
  output logic             busy,
  output logic             reveal_done,
  output logic [CNT_W-1:0] flag_cnt,
  output logic [CNT_W-1:0] revealed_cnt,
  output logic             game_over,
  output logic             game_won
);
  localparam int N  = MAX_DIM * MAX_DIM;
  localparam int AW = $clog2(N);
  localparam int SW = 2 * IDX_W;
  typedef enum logic [2:0] {CLEAR, IDLE, CHECK, SCAN, DRAIN, WRITE} state_t;
  state_t r_state, w_next;
  logic [3:0]       r_mem [N];
  logic [AW-1:0]    r_clr;
  logic [IDX_W-1:0] r_x, r_y;
  logic             r_ev_click, r_ev_exp, r_ev_flag;
  logic [2:0]       r_n;
  logic             r_pend;
  logic [3:0]       r_sum;
  logic [IDX_W:0]   w_dx, w_dy, w_nx, w_ny;
  logic [3:0]       w_tile, w_wd;
  logic [AW-1:0]    w_wa;
  logic [SW-1:0]    w_safe, w_rev_nx;
  logic             w_mask, w_cap, w_exp, w_flag_on, w_flag_off, w_we, w_draw_oob;

  function automatic logic [AW-1:0] idx(input logic [IDX_W-1:0] x, input logic [IDX_W-1:0] y);
    return AW'(y * MAX_DIM + x);
  endfunction

  // Neighbour offsets in NW,N,NE,W,E,SW,S,SE order; -1 wraps high so one >= dim test masks both edges
  assign w_dx       = (r_n == 3'd0 || r_n == 3'd3 || r_n == 3'd5) ? '1 :
                      (r_n == 3'd2 || r_n == 3'd4 || r_n == 3'd7) ? (IDX_W+1)'(1) : '0;
  assign w_dy       = (r_n < 3'd3) ? '1 : (r_n > 3'd4) ? (IDX_W+1)'(1) : '0;
  assign w_nx       = {1'b0, r_x} + w_dx;
  assign w_ny       = {1'b0, r_y} + w_dy;
  assign w_mask     = w_nx >= {1'b0, dim} || w_ny >= {1'b0, dim};
  assign mine_rd_x  = (r_state == SCAN && !w_mask) ? w_nx[IDX_W-1:0] : '0;
  assign mine_rd_y  = (r_state == SCAN && !w_mask) ? w_ny[IDX_W-1:0] : '0;
  assign w_tile     = r_mem[idx(r_x, r_y)];
  assign w_cap      = r_state == IDLE && !game_over && !game_won && !r_ev_click && !r_ev_exp;
  assign w_exp      = r_state == IDLE && r_ev_exp;
  assign w_flag_on  = r_state == IDLE && r_ev_flag && w_tile == 4'd9;
  assign w_flag_off = r_state == IDLE && r_ev_flag && w_tile == 4'd10;
  assign w_we       = r_state == CLEAR || r_state == WRITE || w_exp || w_flag_on || w_flag_off;
  assign w_wa       = r_state == CLEAR ? r_clr : idx(r_x, r_y);
  assign w_wd       = (r_state == CLEAR || w_flag_off) ? 4'd9 : w_exp ? 4'd11 : w_flag_on ? 4'd10 : r_sum;
  assign w_safe     = SW'(dim) * SW'(dim) - SW'(mines);
  assign w_rev_nx   = SW'(revealed_cnt) + SW'(1);
  assign w_draw_oob = draw_x >= dim || draw_y >= dim;
  assign busy       = r_state != IDLE || r_ev_click;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) r_state <= CLEAR;
    else      r_state <= w_next;
  end

  // Next-state logic; new_game overrides every state
  always_comb begin
    w_next = r_state;
    case (r_state)
      CLEAR:   w_next = r_clr == AW'(N - 1) ? IDLE : CLEAR;
      IDLE:    w_next = r_ev_click ? CHECK : IDLE;
      CHECK:   w_next = w_tile == 4'd9 ? SCAN : IDLE;
      SCAN:    w_next = r_n == 3'd7 ? DRAIN : SCAN;
      DRAIN:   w_next = WRITE;
      default: w_next = IDLE;
    endcase
    if (new_game) w_next = CLEAR;
  end

  // Event capture stage, neighbour accumulation, counters and status
  always_ff @(posedge clk) begin
    if (!rst || new_game) begin
      r_clr        <= '0;
      r_x          <= '0;
      r_y          <= '0;
      r_ev_click   <= 1'b0;
      r_ev_exp     <= 1'b0;
      r_ev_flag    <= 1'b0;
      r_n          <= '0;
      r_pend       <= 1'b0;
      r_sum        <= '0;
      reveal_done  <= 1'b0;
      flag_cnt     <= '0;
      revealed_cnt <= '0;
      game_over    <= 1'b0;
      game_won     <= 1'b0;
    end else begin
      r_clr       <= r_state == CLEAR ? r_clr + AW'(1) : r_clr;
      r_x         <= w_cap ? tile_x : r_x;
      r_y         <= w_cap ? tile_y : r_y;
      r_ev_exp    <= w_cap && explode;
      r_ev_click  <= w_cap && !explode && click_valid;
      r_ev_flag   <= w_cap && !explode && !click_valid && flag_valid;
      r_n         <= r_state == SCAN ? r_n + 3'd1 : '0;
      r_pend      <= r_state == SCAN && !w_mask;
      r_sum       <= r_state == CHECK ? '0 :
                     (r_state == SCAN || r_state == DRAIN) ? r_sum + 4'(r_pend & mine_rd_bit) : r_sum;
      reveal_done <= r_state == WRITE;
      flag_cnt    <= w_flag_on ? flag_cnt + CNT_W'(1) : w_flag_off ? flag_cnt - CNT_W'(1) : flag_cnt;
      if (w_exp) game_over <= 1'b1;
      if (r_state == WRITE) begin
        revealed_cnt <= revealed_cnt + CNT_W'(1);
        if (w_rev_nx == w_safe) game_won <= 1'b1;
      end
    end
  end

  // Tile memory write port and registered drawing read port
  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_wa] <= w_wd;
    draw_state <= w_draw_oob ? 4'd9 : r_mem[idx(draw_x, draw_y)];
  end
endmodule
